// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage: IF/ID pipeline register with a one-entry skid buffer and a registered in_ready.
// Optional back-pressure counter output stall_cnt is enabled by defining IF_ID_STALL_CNT_EN.
module if_id_skid_stage #(
  parameter int              XLEN = 32,
  parameter logic [XLEN-1:0] NOP  = 'h13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
  state_t          r_state, w_next;
  logic            r_in_ready;
  logic [XLEN-1:0] r_main_pc, r_main_inst, r_skid_pc, r_skid_inst;
  logic            w_in_fire, w_out_fire, w_load_main, w_load_skid, w_main_from_skid;
  assign out_valid  = r_state != EMPTY;
  assign in_ready   = r_in_ready;
  assign out_pc     = r_main_pc;
  assign out_inst   = out_valid ? r_main_inst : NOP;
  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = out_valid & out_ready;
  always_comb begin
    w_next           = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    if (flush) w_next = EMPTY;
    else
      case (r_state)
        EMPTY: begin
          w_load_main = w_in_fire;
          w_next      = w_in_fire ? FULL : EMPTY;
        end
        FULL: begin
          w_load_main = w_in_fire & w_out_fire;
          w_load_skid = w_in_fire & ~w_out_fire;
          w_next      = w_load_skid ? SKID : (w_out_fire & ~w_in_fire) ? EMPTY : FULL;
        end
        SKID: begin
          w_main_from_skid = out_ready;
          w_next           = out_ready ? FULL : SKID;
        end
        default: w_next = EMPTY;
      endcase
  end
  // in_ready is derived from the next state so it never depends combinationally on out_ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_main_pc   <= '0;
      r_main_inst <= NOP;
      r_skid_pc   <= '0;
      r_skid_inst <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= w_next != SKID;
      if (w_load_main) begin
        r_main_pc   <= in_pc;
        r_main_inst <= in_inst;
      end else if (w_main_from_skid) begin
        r_main_pc   <= r_skid_pc;
        r_main_inst <= r_skid_inst;
      end
      if (w_load_skid) begin
        r_skid_pc   <= in_pc;
        r_skid_inst <= in_inst;
      end
    end
  end
`ifdef IF_ID_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  assign stall_cnt = r_stall_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_stall_cnt <= '0;
    else if (out_valid & ~out_ready & (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
  end
`endif
endmodule

// File: doc/if_id_skid_stage.md
IF_ID_SKID_STAGE -- requirements
Module: if_id_skid_stage

Interface
REQ-001 Parameter XLEN, default 32: width of the PC and instruction fields.
REQ-002 Parameter NOP, default 32'h00000013: instruction word presented when the stage holds no valid entry.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous kill of all held entries (branch/jump redirect).
REQ-006 in_valid  input  1  upstream fetch presents in_pc/in_inst.
REQ-007 in_ready  output  1  stage accepts input this cycle.
REQ-008 in_pc  input  XLEN  fetched PC.
REQ-009 in_inst  input  XLEN  fetched instruction.
REQ-010 out_valid  output  1  decode-side entry valid.
REQ-011 out_ready  input  1  decode consumes the entry this cycle.
REQ-012 out_pc  output  XLEN  PC of the head entry.
REQ-013 out_inst  output  XLEN  instruction of the head entry.
REQ-014 stall_cnt  output  16  back-pressure cycle count; present only per REQ-030.

Function
REQ-015 The stage SHALL hold a main entry and a skid entry, with FSM states EMPTY, FULL (main valid) and SKID (main and skid valid).
REQ-016 Transfers: input when in_valid & in_ready; output when out_valid & out_ready.
REQ-017 in_ready SHALL be a registered signal, 1 in EMPTY and FULL, 0 in SKID, with no combinational path from out_ready.
REQ-018 out_valid SHALL be 1 exactly in FULL and SKID; out_pc/out_inst SHALL always come from the main entry.
REQ-019 EMPTY: in_valid -> load main, go to FULL; else stay in EMPTY.
REQ-020 FULL: in & out -> reload main, stay; out only -> EMPTY; in only -> load skid, go to SKID; neither -> stay.
REQ-021 SKID: out_ready -> main <= skid, go to FULL; else hold both entries.
REQ-022 Latency SHALL be 1 cycle (input accepted at edge N is visible at out_* after edge N); sustained throughput SHALL be 1 entry/cycle.
REQ-023 Ordering SHALL be strict FIFO; no entry dropped or duplicated except by flush.
REQ-024 flush SHALL take priority over all transfers: next state EMPTY, and any input offered in the flush cycle is discarded.
REQ-025 In EMPTY, out_inst SHALL equal NOP and out_pc SHALL hold its last value.
REQ-026 While out_valid & !out_ready, out_pc/out_inst SHALL remain stable.

Reset
REQ-027 Asserting rst SHALL immediately force: state EMPTY, out_valid 0, in_ready 1, out_pc 0, out_inst NOP, skid contents 0, stall_cnt 0.
REQ-028 Reset mid-operation SHALL discard both entries with no output transfer.
REQ-029 After deassertion, the first rising edge SHALL already accept input.

Configuration
REQ-030 Macro IF_ID_STALL_CNT_EN defined: stall_cnt increments each cycle with out_valid & !out_ready, saturates at 16'hFFFF, and is cleared only by rst (flush does not clear it).
REQ-031 IF_ID_STALL_CNT_EN undefined: stall_cnt port and its counter are absent; all other behaviour is identical.

Verification
REQ-032 Reset, then in_valid=1 with pc 0x0,0x4,0x8 and out_ready=1 -> out_pc 0x0,0x4,0x8 on consecutive cycles, in_ready constantly 1.
REQ-033 FULL with pc 0x10, out_ready=0, offer pc 0x14 -> SKID, in_ready=0, out_pc stays 0x10; set out_ready=1 -> out 0x10 then 0x14.
REQ-034 SKID state with flush=1 and in_valid=1 (pc 0x20) -> next cycle out_valid=0, out_inst=0x00000013, in_ready=1; 0x20 never appears at output.
REQ-035 rst asserted asynchronously mid-stream -> out_valid=0 and out_pc=0 before the next clock edge.
REQ-036 With IF_ID_STALL_CNT_EN: hold out_ready=0 for 5 cycles with a valid entry -> stall_cnt=5; force 70000 cycles -> stall_cnt=0xFFFF.
